// File: rtl/uart_frame_tx.sv
// Transmit-side framer: buffers payload bytes in a FIFO and emits HDR, LEN_HI, LEN_LO, payload, TRL
// as a valid/ready byte stream towards the UART serializer.
module uart_frame_tx #(
    parameter int          DEPTH = 16,
    parameter logic [7:0]  HDR   = 8'hAA,
    parameter logic [7:0]  TRL   = 8'hBB
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        start,
    input  logic [15:0] len,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic        full,
    output logic        empty,
    output logic        overflow
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_TRL
    } state_t;

    state_t        r_state, w_stateNext;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr, r_rdPtr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic [7:0]    r_txData, w_txDataNext;
    logic          r_txValid, w_txValidNext;
    logic [15:0]   r_cnt, w_cntNext;
    logic [15:0]   r_len, w_lenNext;
    logic          r_done, w_doneNext;
    logic          w_push, w_pop, w_xfer, w_full, w_empty;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = wr_en && !w_full;
    assign w_xfer  = r_txValid && tx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wrPtr <= r_wrPtr + AW'(1);
            if (w_pop)
                r_rdPtr <= r_rdPtr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (wr_en && w_full)
                r_overflow <= 1'b1;
        end
    end

    // Storage is not reset; pointer reset is what discards stale contents.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wrPtr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_txData  <= 8'h00;
            r_txValid <= 1'b0;
            r_cnt     <= 16'd0;
            r_len     <= 16'd0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_txData  <= w_txDataNext;
            r_txValid <= w_txValidNext;
            r_cnt     <= w_cntNext;
            r_len     <= w_lenNext;
            r_done    <= w_doneNext;
        end
    end

    // Payload loads happen in the same cycle the previous byte transfers, keeping 1 byte/cycle.
    always_comb begin
        w_stateNext   = r_state;
        w_txDataNext  = r_txData;
        w_txValidNext = r_txValid;
        w_cntNext     = r_cnt;
        w_lenNext     = r_len;
        w_doneNext    = 1'b0;
        w_pop         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_stateNext   = S_HDR;
                    w_lenNext     = len;
                    w_cntNext     = len;
                    w_txDataNext  = HDR;
                    w_txValidNext = 1'b1;
                end
            end
            S_HDR: begin
                if (w_xfer) begin
                    w_txDataNext = r_len[15:8];
                    w_stateNext  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_xfer) begin
                    w_txDataNext = r_len[7:0];
                    w_stateNext  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (w_xfer) begin
                    if (r_cnt != 16'd0) begin
                        w_stateNext = S_DATA;
                        if (!w_empty) begin
                            w_pop         = 1'b1;
                            w_txDataNext  = r_mem[r_rdPtr];
                            w_txValidNext = 1'b1;
                            w_cntNext     = r_cnt - 16'd1;
                        end else begin
                            w_txValidNext = 1'b0;
                        end
                    end else begin
                        w_txDataNext = TRL;
                        w_stateNext  = S_TRL;
                    end
                end
            end
            S_DATA: begin
                if (!r_txValid || w_xfer) begin
                    if (r_cnt == 16'd0) begin
                        w_txDataNext  = TRL;
                        w_txValidNext = 1'b1;
                        w_stateNext   = S_TRL;
                    end else if (!w_empty) begin
                        w_pop         = 1'b1;
                        w_txDataNext  = r_mem[r_rdPtr];
                        w_txValidNext = 1'b1;
                        w_cntNext     = r_cnt - 16'd1;
                    end else begin
                        w_txValidNext = 1'b0;
                    end
                end
            end
            S_TRL: begin
                if (w_xfer) begin
                    w_txValidNext = 1'b0;
                    w_doneNext    = 1'b1;
                    w_stateNext   = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    assign tx_data  = r_txData;
    assign tx_valid = r_txValid;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_overflow;

endmodule
